// File: rtl/ic_mem_resp_pkg.sv
// Shared types and constants for the instruction-cache fill responder.
package ic_pkg;

    localparam int IC_MEM_XID_BITS = 2;
    localparam int IC_LINE_BEATS   = 8;
    localparam int IC_BEAT_BITS    = 16;
    localparam int IC_LINE_BITS    = IC_LINE_BEATS * IC_BEAT_BITS;

    typedef struct packed {
        logic [26:4]                addr;
        logic [IC_MEM_XID_BITS-1:0] xid;
    } ic_mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEAT,
        ST_RESP
    } ic_resp_state_e;

endpackage

// File: rtl/ic_mem_resp_req_fifo.sv
// In-order request queue: power-of-two depth, pointers wrap naturally.
module ic_req_fifo
    import ic_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  ic_mem_req_t i_din,
    input  logic        i_pop,
    output ic_mem_req_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    ic_mem_req_t   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/ic_mem_resp.sv
// Cache fill responder: queues line requests, bursts 16-bit beats from the
// backend, assembles a 128-bit line and returns it with a one-cycle pulse.
module ic_mem_resp
    import ic_pkg::*;
#(
    parameter int unsigned Q_DEPTH    = 4,
    parameter int unsigned LINE_BEATS = IC_LINE_BEATS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [26:4]                ic_mem_addr,
    input  logic [IC_MEM_XID_BITS-1:0] ic_mem_xid,
    input  logic                       ic_mem_re,
    output logic                       mem_ic_ready,
    output logic                       mem_ic_valid,
    output logic [IC_MEM_XID_BITS-1:0] mem_ic_xid,
    output logic [IC_LINE_BITS-1:0]    mem_ic_data,
    output logic [26:4]                bk_addr,
    output logic                       bk_req,
    input  logic                       bk_gnt,
    input  logic                       bk_rvalid,
    input  logic [IC_BEAT_BITS-1:0]    bk_rdata
);

    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    ic_resp_state_e r_state;
    ic_resp_state_e w_state_nxt;

    logic                       r_ready_en;
    logic [2:0]                 r_beat_cnt;
    logic [IC_MEM_XID_BITS-1:0] r_xid;
    logic [26:4]                r_addr;
    logic [IC_LINE_BITS-1:0]    r_line;
    logic [IC_LINE_BITS-1:0]    r_out_data;
    logic [IC_MEM_XID_BITS-1:0] r_out_xid;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_beat_we;
    logic                    w_last_beat;
    ic_mem_req_t             w_req;
    ic_mem_req_t             w_head;
    logic [IC_LINE_BITS-1:0] w_line_nxt;

    // Ready comes only from registered state, so a same-cycle pop never bypasses.
    assign mem_ic_ready = r_ready_en && !w_full;
    assign w_push       = ic_mem_re && mem_ic_ready;
    assign w_req        = '{addr: ic_mem_addr, xid: ic_mem_xid};

    ic_req_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        bk_req       = 1'b0;
        mem_ic_valid = 1'b0;
        w_pop        = 1'b0;
        w_beat_we    = 1'b0;
        w_last_beat  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bk_req = 1'b1;
                if (bk_gnt) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (bk_rvalid) begin
                    w_beat_we = 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_last_beat = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                mem_ic_valid = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_line_nxt = r_line;
        w_line_nxt[{r_beat_cnt, 4'b0000} +: IC_BEAT_BITS] = bk_rdata;
    end

    // Output registers load only with a complete line, so they hold between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_en <= 1'b0;
            r_beat_cnt <= '0;
            r_xid      <= '0;
            r_addr     <= '0;
            r_line     <= '0;
            r_out_data <= '0;
            r_out_xid  <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_pop) begin
                r_xid      <= w_head.xid;
                r_addr     <= w_head.addr;
                r_beat_cnt <= '0;
            end
            if (w_beat_we) begin
                r_line     <= w_line_nxt;
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
            if (w_last_beat) begin
                r_out_data <= w_line_nxt;
                r_out_xid  <= r_xid;
            end
        end
    end

    assign bk_addr     = (r_state == ST_REQ) ? w_head.addr : r_addr;
    assign mem_ic_data = r_out_data;
    assign mem_ic_xid  = r_out_xid;

    a_valid_single: assert property (@(posedge clk) disable iff (rst)
        mem_ic_valid |=> !mem_ic_valid);

    a_req_only_in_req: assert property (@(posedge clk) disable iff (rst)
        bk_req |-> (r_state == ST_REQ));

endmodule
